// File: rtl/aes_sbox_arbiter.sv
// aes_sbox_arbiter: shares one combinational 32-bit AES S-box between the
// round datapath (client 0) and key expansion (client 1).
// Behaviour:
//   - Two-stage pipeline with a fixed latency of 2 cycles.
//   - Round-robin or fixed-priority arbitration, selected by FIXED_PRIO.
//   - A client may lock the S-box for a multi-beat burst.
// Optional macro AES_SBOX_ARB_STATS_EN adds saturating grant/stall counters.
module aes_sbox_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit RR_INIT    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_word,
    input  logic        req0_lock,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_word,
    input  logic        req1_valid,
    input  logic [31:0] req1_word,
    input  logic        req1_lock,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_word,
    output logic [31:0] sbox_in,
    input  logic [31:0] sbox_out
`ifdef AES_SBOX_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1,
    output logic [15:0] stat_stall
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_rr_ptr;        // client favoured on the next contention
    logic        w_ready0;
    logic        w_ready1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_acc;
    logic        w_acc_lock;
    logic        r_s1_valid;
    logic        r_s1_id;
    logic [31:0] r_s1_word;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic [31:0] r_rsp0_word;
    logic [31:0] r_rsp1_word;

    // Grant decision: lock owner first, then single requester, then policy.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (reset) begin
            w_ready0 = 1'b0;
            w_ready1 = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req0_valid && req1_valid) begin
                        if (FIXED_PRIO) begin
                            w_ready0 = 1'b1;
                        end else if (r_rr_ptr) begin
                            w_ready1 = 1'b1;
                        end else begin
                            w_ready0 = 1'b1;
                        end
                    end else begin
                        w_ready0 = req0_valid;
                        w_ready1 = req1_valid;
                    end
                end
                ST_LOCK0: w_ready0 = req0_valid;
                ST_LOCK1: w_ready1 = req1_valid;
                default: begin
                    w_ready0 = 1'b0;
                    w_ready1 = 1'b0;
                end
            endcase
        end
    end

    assign w_acc0     = req0_valid & w_ready0;
    assign w_acc1     = req1_valid & w_ready1;
    assign w_acc      = w_acc0 | w_acc1;
    assign w_acc_lock = w_acc1 ? req1_lock : req0_lock;

    // Next-state: enter a lock on a locked beat, leave it on the owner's unlocked beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && w_acc_lock) begin
                    w_state_next = w_acc1 ? ST_LOCK1 : ST_LOCK0;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOCK0: begin
                if (w_acc0 && !req0_lock) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_LOCK0;
                end
            end
            ST_LOCK1: begin
                if (w_acc1 && !req1_lock) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_LOCK1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Arbitration state and round-robin pointer (favour the other client after each beat).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= RR_INIT;
        end else begin
            r_state <= w_state_next;
            if (w_acc) begin
                r_rr_ptr <= ~w_acc1;
            end
        end
    end

    // Stage 1: capture the accepted word and its issuer; the word drives the S-box.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_word  <= 32'd0;
        end else begin
            r_s1_valid <= w_acc;
            if (w_acc) begin
                r_s1_id   <= w_acc1;
                r_s1_word <= w_acc1 ? req1_word : req0_word;
            end
        end
    end

    // Stage 2: capture the S-box result and route it to the issuing client.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_word  <= 32'd0;
            r_rsp1_word  <= 32'd0;
        end else begin
            r_rsp0_valid <= r_s1_valid & ~r_s1_id;
            r_rsp1_valid <= r_s1_valid & r_s1_id;
            if (r_s1_valid && !r_s1_id) begin
                r_rsp0_word <= sbox_out;
            end
            if (r_s1_valid && r_s1_id) begin
                r_rsp1_word <= sbox_out;
            end
        end
    end

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_word  = r_rsp0_word;
    assign rsp1_word  = r_rsp1_word;
    assign sbox_in    = r_s1_word;

`ifdef AES_SBOX_ARB_STATS_EN
    logic [15:0] r_stat_grant0;
    logic [15:0] r_stat_grant1;
    logic [15:0] r_stat_stall;
    logic [1:0]  w_stall_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    assign w_stall_inc = {1'b0, req0_valid & ~w_ready0} + {1'b0, req1_valid & ~w_ready1};

    // Saturating statistics: beats granted per client and stalled requester-cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_grant0 <= 16'd0;
            r_stat_grant1 <= 16'd0;
            r_stat_stall  <= 16'd0;
        end else begin
            r_stat_grant0 <= sat_add(r_stat_grant0, {1'b0, w_acc0});
            r_stat_grant1 <= sat_add(r_stat_grant1, {1'b0, w_acc1});
            r_stat_stall  <= sat_add(r_stat_stall, w_stall_inc);
        end
    end

    assign stat_grant0 = r_stat_grant0;
    assign stat_grant1 = r_stat_grant1;
    assign stat_stall  = r_stat_stall;
`endif

endmodule
